timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_pkg.sv | 30 +++
 rtl/timer_channel.sv | 120 ++++++++++++
 rtl/timer_bank.sv | 78 +++++++
 tb/tb_timer_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types for the timer bank
//
// Purpose: mode and channel-state enumerations used by timer_bank and
// timer_channel, plus the decode from the raw two-bit mode field.
// Ports: none (package).

package timer_pkg;

   typedef enum logic [1:0] {
      TMR_OFF      = 2'b00,
      TMR_ONESHOT  = 2'b01,
      TMR_PERIODIC = 2'b10
   } tmr_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } tmr_state_e;

   // The reserved encoding 2'b11 behaves exactly like a disabled channel.
   function automatic tmr_mode_e decode_mode(input logic [1:0] bits);
      case (bits)
         2'b01:   return TMR_ONESHOT;
         2'b10:   return TMR_PERIODIC;
         default: return TMR_OFF;
      endcase
   endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one prescaled compare timer channel
//
// Purpose: single timer with IDLE/RUN/DONE FSM, prescaler, main counter,
// one-cycle expiry pulse and sticky pending flag.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   cfg_we_i   write strobe already decoded for this channel
//   cfg_mode_i raw mode field (00 off, 01 one-shot, 10 periodic, 11 off)
//   cfg_cmp_i  compare value
//   cfg_presc_i prescale divisor minus one
//   irq_ack_i  clear for the pending flag
//   count_o    current main count
//   expire_o   registered one-cycle expiry pulse
//   irq_pend_o sticky pending flag
//   busy_o     high while in RUN

module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we_i,
   input  logic [1:0]         cfg_mode_i,
   input  logic [CNT_W-1:0]   cfg_cmp_i,
   input  logic [PRESC_W-1:0] cfg_presc_i,
   input  logic               irq_ack_i,
   output logic [CNT_W-1:0]   count_o,
   output logic               expire_o,
   output logic               irq_pend_o,
   output logic               busy_o
);

   tmr_state_e         state_q, state_d;
   tmr_mode_e          mode_q, mode_d;
   logic [CNT_W-1:0]   cmp_q, cmp_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               expire_q, expire_d;
   logic               pend_q, pend_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         mode_q   <= TMR_OFF;
         cmp_q    <= '0;
         presc_q  <= '0;
         pcnt_q   <= '0;
         count_q  <= '0;
         expire_q <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cmp_q    <= cmp_d;
         presc_q  <= presc_d;
         pcnt_q   <= pcnt_d;
         count_q  <= count_d;
         expire_q <= expire_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cmp_d    = cmp_q;
      presc_d  = presc_q;
      pcnt_d   = pcnt_q;
      count_d  = count_q;
      expire_d = 1'b0;
      // An ack clears the flag unless an expiry below sets it again.
      pend_d   = pend_q & ~irq_ack_i;

      if (cfg_we_i) begin
         // A write overrides anything the running timer would have done
         // this cycle, including an expiry that was due.
         mode_d  = decode_mode(cfg_mode_i);
         cmp_d   = cfg_cmp_i;
         presc_d = cfg_presc_i;
         pcnt_d  = '0;
         count_d = '0;
         state_d = (mode_d == TMR_OFF) ? IDLE : RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (pcnt_q == presc_q) begin
                  pcnt_d = '0;
                  if (count_q == cmp_q) begin
                     expire_d = 1'b1;
                     pend_d   = 1'b1;
                     if (mode_q == TMR_PERIODIC) begin
                        count_d = '0;
                     end else begin
                        state_d = DONE;
                     end
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end else begin
                  pcnt_d = pcnt_q + PRESC_W'(1);
               end
            end
            default: begin
               // IDLE and DONE freeze count and prescaler.
            end
         endcase
      end
   end

   assign count_o    = count_q;
   assign expire_o   = expire_q;
   assign irq_pend_o = pend_q;
   assign busy_o     = (state_q == RUN);

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of independent prescaled compare timers
//
// Purpose: NUM_CH timer_channel instances with shared configuration port,
// per-channel interrupt acknowledge and a combinational count readback mux.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   cfg_we    configuration write strobe
//   cfg_ch    channel addressed by the write (out-of-range writes ignored)
//   cfg_mode  00 off, 01 one-shot, 10 periodic, 11 off
//   cfg_cmp   compare value
//   cfg_presc prescale divisor minus one
//   irq_ack   per-channel pending clear
//   rd_ch     channel selected for readback
//   rd_count  count of rd_ch, 0 when rd_ch is out of range
//   expire    per-channel one-cycle expiry pulse
//   irq_pend  per-channel sticky pending flag
//   busy      per-channel RUN indicator

module timer_bank
   import timer_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [1:0]         cfg_mode,
   input  logic [CNT_W-1:0]   cfg_cmp,
   input  logic [PRESC_W-1:0] cfg_presc,
   input  logic [NUM_CH-1:0]  irq_ack,
   input  logic [CH_W-1:0]    rd_ch,
   output logic [CNT_W-1:0]   rd_count,
   output logic [NUM_CH-1:0]  expire,
   output logic [NUM_CH-1:0]  irq_pend,
   output logic [NUM_CH-1:0]  busy
);

   logic [CNT_W-1:0] count_w [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_we;

      // Only in-range addresses can match, so stray writes fall through.
      assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

      timer_channel #(
         .CNT_W   (CNT_W),
         .PRESC_W (PRESC_W)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .cfg_we_i    (ch_we),
         .cfg_mode_i  (cfg_mode),
         .cfg_cmp_i   (cfg_cmp),
         .cfg_presc_i (cfg_presc),
         .irq_ack_i   (irq_ack[i]),
         .count_o     (count_w[i]),
         .expire_o    (expire[i]),
         .irq_pend_o  (irq_pend[i]),
         .busy_o      (busy[i])
      );
   end

   always_comb begin
      rd_count = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i)) begin
            rd_count = count_w[i];
         end
      end
   end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed self-checking bench for timer_bank

module tb_timer_bank;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // DUT a: default geometry, four channels, 32-bit counters.
   logic        cfg_we_a;
   logic [1:0]  cfg_ch_a;
   logic [1:0]  cfg_mode_a;
   logic [31:0] cfg_cmp_a;
   logic [7:0]  cfg_presc_a;
   logic [3:0]  irq_ack_a;
   logic [1:0]  rd_ch_a;
   logic [31:0] rd_count_a;
   logic [3:0]  expire_a;
   logic [3:0]  irq_pend_a;
   logic [3:0]  busy_a;

   // DUT b: three channels so an out-of-range address exists, 8-bit counters.
   logic        cfg_we_b;
   logic [1:0]  cfg_ch_b;
   logic [1:0]  cfg_mode_b;
   logic [7:0]  cfg_cmp_b;
   logic [7:0]  cfg_presc_b;
   logic [2:0]  irq_ack_b;
   logic [1:0]  rd_ch_b;
   logic [7:0]  rd_count_b;
   logic [2:0]  expire_b;
   logic [2:0]  irq_pend_b;
   logic [2:0]  busy_b;

   int vectors = 0;
   int miscompares = 0;

   timer_bank #(.NUM_CH(4), .CNT_W(32), .PRESC_W(8)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we_a),
      .cfg_ch    (cfg_ch_a),
      .cfg_mode  (cfg_mode_a),
      .cfg_cmp   (cfg_cmp_a),
      .cfg_presc (cfg_presc_a),
      .irq_ack   (irq_ack_a),
      .rd_ch     (rd_ch_a),
      .rd_count  (rd_count_a),
      .expire    (expire_a),
      .irq_pend  (irq_pend_a),
      .busy      (busy_a)
   );

   timer_bank #(.NUM_CH(3), .CNT_W(8), .PRESC_W(8)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we_b),
      .cfg_ch    (cfg_ch_b),
      .cfg_mode  (cfg_mode_b),
      .cfg_cmp   (cfg_cmp_b),
      .cfg_presc (cfg_presc_b),
      .irq_ack   (irq_ack_b),
      .rd_ch     (rd_ch_b),
      .rd_count  (rd_count_b),
      .expire    (expire_b),
      .irq_pend  (irq_pend_b),
      .busy      (busy_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge right after the write edge.
   task automatic write_a(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [31:0] cmp, input logic [7:0] presc);
      cfg_we_a    = 1'b1;
      cfg_ch_a    = ch;
      cfg_mode_a  = mode;
      cfg_cmp_a   = cmp;
      cfg_presc_a = presc;
      @(negedge clk);
      cfg_we_a    = 1'b0;
   endtask

   task automatic write_b(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [7:0] cmp, input logic [7:0] presc);
      cfg_we_b    = 1'b1;
      cfg_ch_b    = ch;
      cfg_mode_b  = mode;
      cfg_cmp_b   = cmp;
      cfg_presc_b = presc;
      @(negedge clk);
      cfg_we_b    = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      // Writes and acks during reset must be swallowed.
      cfg_we_a = 1'b1; cfg_ch_a = 2'd0; cfg_mode_a = 2'b10; cfg_cmp_a = 32'd0;
      cfg_presc_a = 8'd0; irq_ack_a = 4'hF; rd_ch_a = 2'd0;
      cfg_we_b = 1'b0; cfg_ch_b = 2'd0; cfg_mode_b = 2'b00; cfg_cmp_b = 8'd0;
      cfg_presc_b = 8'd0; irq_ack_b = 3'b000; rd_ch_b = 2'd0;
      step(2);
      check("reset_busy", busy_a, 4'h0);
      check("reset_expire", expire_a, 4'h0);
      check("reset_pend", irq_pend_a, 4'h0);
      check("reset_rdcount", rd_count_a, 32'd0);
      check("reset_busy_b", busy_b, 3'b000);
      rst = 1'b1; cfg_we_a = 1'b0; irq_ack_a = 4'h0;
      step(1);
      check("post_reset_busy", busy_a, 4'h0);

      // ch0 one-shot, cmp=3, presc=0: expiry pulse after edge 4.
      rd_ch_a = 2'd0;
      write_a(2'd0, 2'b01, 32'd3, 8'd0);
      check("os_busy_e0", busy_a[0], 1'b1);
      check("os_count_e0", rd_count_a, 32'd0);
      for (int e = 1; e <= 3; e++) begin
         step(1);
         check("os_expire_pre", expire_a[0], 1'b0);
         check("os_count", rd_count_a, 32'(e));
      end
      step(1);
      check("os_expire_e4", expire_a[0], 1'b1);
      check("os_busy_e4", busy_a[0], 1'b0);
      check("os_pend_e4", irq_pend_a[0], 1'b1);
      check("os_count_e4", rd_count_a, 32'd3);
      step(1);
      check("os_expire_e5", expire_a[0], 1'b0);
      check("os_count_e5", rd_count_a, 32'd3);
      irq_ack_a = 4'b0001;
      step(1);
      irq_ack_a = 4'b0000;
      check("os_ack", irq_pend_a[0], 1'b0);

      // ch1 periodic, cmp=1, presc=2: expiry every 6 edges.
      write_a(2'd1, 2'b10, 32'd1, 8'd2);
      for (int e = 1; e <= 18; e++) begin
         step(1);
         check("per_expire", expire_a[1], (e % 6 == 0) ? 1'b1 : 1'b0);
      end
      check("per_pend", irq_pend_a[1], 1'b1);
      // Disabling must not clear the pending flag.
      write_a(2'd1, 2'b00, 32'd0, 8'd0);
      check("per_off_busy", busy_a[1], 1'b0);
      check("per_off_pend", irq_pend_a[1], 1'b1);
      irq_ack_a = 4'b0010;
      step(1);
      irq_ack_a = 4'b0000;
      check("per_ack", irq_pend_a[1], 1'b0);

      // ch2 one-shot, cmp=1, presc=1: expiry at edge 4 collides with an ack.
      write_a(2'd2, 2'b01, 32'd1, 8'd1);
      step(3);
      irq_ack_a = 4'b0100;
      step(1);
      irq_ack_a = 4'b0000;
      check("ackx_expire", expire_a[2], 1'b1);
      check("ackx_pend", irq_pend_a[2], 1'b1);
      step(1);
      check("ackx_pend_hold", irq_pend_a[2], 1'b1);
      irq_ack_a = 4'b0100;
      step(1);
      irq_ack_a = 4'b0000;
      check("ackx_clear", irq_pend_a[2], 1'b0);

      // ch3 periodic cmp=2 rewritten to cmp=5 in its expiry cycle.
      rd_ch_a = 2'd3;
      write_a(2'd3, 2'b10, 32'd2, 8'd0);
      step(2);
      write_a(2'd3, 2'b10, 32'd5, 8'd0);
      check("rw_expire", expire_a[3], 1'b0);
      check("rw_count", rd_count_a, 32'd0);
      check("rw_pend", irq_pend_a[3], 1'b0);
      for (int e = 1; e <= 5; e++) begin
         step(1);
         check("rw_expire_pre", expire_a[3], 1'b0);
      end
      step(1);
      check("rw_expire_e6", expire_a[3], 1'b1);
      write_a(2'd3, 2'b11, 32'd0, 8'd0);
      check("rw_reserved_busy", busy_a[3], 1'b0);

      // ch0 periodic cmp=0 presc=0 expires every cycle; ch2 every other.
      rd_ch_a = 2'd0;
      write_a(2'd0, 2'b10, 32'd0, 8'd0);
      for (int e = 1; e <= 5; e++) begin
         step(1);
         check("fast_expire", expire_a[0], 1'b1);
         check("fast_count", rd_count_a, 32'd0);
      end
      write_a(2'd2, 2'b10, 32'd1, 8'd0);
      check("multi_e0", expire_a, 4'b0001);
      for (int e = 1; e <= 4; e++) begin
         step(1);
         check("multi_expire", expire_a, (e % 2 == 0) ? 4'b0101 : 4'b0001);
      end

      // Reset mid-count dominates a write and an ack.
      rst = 1'b0;
      cfg_we_a = 1'b1; cfg_ch_a = 2'd1; cfg_mode_a = 2'b10; cfg_cmp_a = 32'd0;
      irq_ack_a = 4'hF;
      step(1);
      check("midrst_expire", expire_a, 4'h0);
      check("midrst_pend", irq_pend_a, 4'h0);
      check("midrst_busy", busy_a, 4'h0);
      check("midrst_count", rd_count_a, 32'd0);
      rst = 1'b1; cfg_we_a = 1'b0; irq_ack_a = 4'h0;
      for (int e = 1; e <= 3; e++) begin
         step(1);
         check("postrst_quiet", {busy_a, expire_a}, 8'h00);
      end

      // DUT b: a write to channel 3 of a three-channel bank is ignored.
      write_b(2'd1, 2'b01, 8'd2, 8'd0);
      write_b(2'd3, 2'b10, 8'd0, 8'd0);
      check("badch_busy", busy_b, 3'b010);
      check("badch_expire", expire_b, 3'b000);
      rd_ch_b = 2'd1;
      #1;
      check("badch_count", rd_count_b, 8'd1);
      rd_ch_b = 2'd3;
      #1;
      check("badch_rd_oob", rd_count_b, 8'd0);
      step(2);
      check("badch_expire_ch1", expire_b, 3'b010);

      // DUT b: cmp=255 periodic expires after 256 edges.
      rd_ch_b = 2'd0;
      write_b(2'd0, 2'b10, 8'hFF, 8'd0);
      step(255);
      check("wide_count_255", rd_count_b, 8'd255);
      check("wide_expire_255", expire_b, 3'b000);
      step(1);
      check("wide_expire_256", expire_b, 3'b001);
      check("wide_count_wrap", rd_count_b, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
